// File: rtl/aes_serial_pkg.sv
// Shared definitions for the AES serial slave: widths, FSM state codes and FIPS-197 vectors.
package aes_serial_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int KEY_W_DEF  = 128;
    localparam int CNT_W_DEF  = 9;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RX_DATA = 3'd1;
    localparam state_t ST_RX_KEY  = 3'd2;
    localparam state_t ST_WAIT    = 3'd3;
    localparam state_t ST_TX      = 3'd4;

    // FIPS-197 appendix C.1 (AES-128) known-answer vector
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_serial_txsr.sv
// Result return path: parallel load of the core result, then one bit per cycle, bit 0 first.
module aes_serial_txsr #(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              so_o,
    output logic              so_vld_o,
    output logic              last_o
);

    localparam int BC_W = $clog2(DATA_W);

    logic [DATA_W-1:0] sr_q;
    logic [BC_W-1:0]   bit_q;
    logic              so_q;
    logic              vld_q;

    // bit_q is the index of the bit currently presented on so
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            bit_q <= '0;
            so_q  <= 1'b0;
            vld_q <= 1'b0;
        end else if (clear_i) begin
            bit_q <= '0;
            so_q  <= 1'b0;
            vld_q <= 1'b0;
        end else if (load_i) begin
            sr_q  <= data_i >> 1;
            bit_q <= '0;
            so_q  <= data_i[0];
            vld_q <= 1'b1;
        end else if (vld_q) begin
            if (last_o) begin
                bit_q <= '0;
                so_q  <= 1'b0;
                vld_q <= 1'b0;
            end else begin
                sr_q  <= sr_q >> 1;
                bit_q <= bit_q + BC_W'(1);
                so_q  <= sr_q[0];
            end
        end
    end

    assign last_o   = vld_q && (bit_q == BC_W'(DATA_W - 1));
    assign so_o     = so_q && vld_q;
    assign so_vld_o = vld_q;

endmodule

// File: rtl/aes_serial_slave.sv
// Serial front end for the AES core: receives data then key on si, returns the result on so.
// Optional sticky abort flag `err` is built when ABORT_STATUS_EN is defined.
module aes_serial_slave
    import aes_serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int KEY_W  = KEY_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              si,
    output logic              so,
    output logic              so_vld,
    output logic              core_start,
    output logic [DATA_W-1:0] core_data,
    output logic [KEY_W-1:0]  core_key,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic              busy
`ifdef ABORT_STATUS_EN
    ,
    output logic              err
`endif
);

    localparam int DI_W = $clog2(DATA_W);
    localparam int KI_W = $clog2(KEY_W);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              start_q, start_d;
    logic              csn_q;
    logic              frame_start, abort, tx_load, tx_last;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        key_d       = key_q;
        start_d     = 1'b0;
        frame_start = 1'b0;
        abort       = 1'b0;
        tx_load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // a frame only opens on a high-to-low cs_n transition
                if (!cs_n && csn_q) begin
                    frame_start = 1'b1;
                    data_d[0]   = si;
                    cnt_d       = CNT_W'(1);
                    state_d     = ST_RX_DATA;
                end
            end
            ST_RX_DATA: begin
                if (cs_n) begin
                    abort = 1'b1;
                end else begin
                    data_d[cnt_q[DI_W-1:0]] = si;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_RX_KEY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RX_KEY: begin
                if (cs_n) begin
                    abort = 1'b1;
                end else begin
                    key_d[cnt_q[KI_W-1:0]] = si;
                    if (cnt_q == CNT_W'(KEY_W - 1)) begin
                        start_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (core_done) begin
                    tx_load = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                if (cs_n) begin
                    abort = 1'b1;
                end else if (tx_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            key_q   <= '0;
            start_q <= 1'b0;
            csn_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            key_q   <= key_d;
            start_q <= start_d;
            csn_q   <= cs_n;
        end
    end

    aes_serial_txsr #(.DATA_W(DATA_W)) u_txsr (
        .clk      (clk),
        .rst      (rst),
        .load_i   (tx_load),
        .clear_i  (abort),
        .data_i   (core_result),
        .so_o     (so),
        .so_vld_o (so_vld),
        .last_o   (tx_last)
    );

`ifdef ABORT_STATUS_EN
    logic err_q, err_d;

    // a set event wins over the clear from a frame opening on the same edge
    always_comb begin
        err_d = err_q;
        if (frame_start) err_d = 1'b0;
        if (abort || (core_done && state_q != ST_WAIT)) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`endif

    assign core_start = start_q;
    assign core_data  = data_q;
    assign core_key   = key_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_serial_slave.sv
// Bench for aes_serial_slave: per-cycle model of the serial protocol plus an expected-bit queue for so.
module tb_aes_serial_slave;

  localparam int DW = 128;
  localparam int KW = 128;

  logic          clk, rst, cs_n, si, core_done;
  logic [DW-1:0] core_result;
  logic          so, so_vld, core_start, busy;
  logic [DW-1:0] core_data;
  logic [KW-1:0] core_key;
`ifdef ABORT_STATUS_EN
  logic          err;
`endif

  aes_serial_slave #(.DATA_W(DW), .KEY_W(KW), .CNT_W(9)) dut (
    .clk         (clk),
    .rst         (rst),
    .cs_n        (cs_n),
    .si          (si),
    .so          (so),
    .so_vld      (so_vld),
    .core_start  (core_start),
    .core_data   (core_data),
    .core_key    (core_key),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy)
`ifdef ABORT_STATUS_EN
    ,
    .err         (err)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // model state: what the outputs must be after the most recent edge
  logic          exp_busy, exp_vld, exp_start, exp_err;
  logic [DW-1:0] exp_data;
  logic [KW-1:0] exp_key;
  logic [0:0]    exp_q[$];
  logic [DW-1:0] got_word;
  int            got_idx;
  int            n_vec, n_err;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: every output compared on every falling edge
  always @(negedge clk) begin
    logic [0:0] e;
    check("busy", 256'(busy), 256'(exp_busy));
    check("so_vld", 256'(so_vld), 256'(exp_vld));
    check("core_start", 256'(core_start), 256'(exp_start));
    check("core_data", 256'(core_data), 256'(exp_data));
    check("core_key", 256'(core_key), 256'(exp_key));
`ifdef ABORT_STATUS_EN
    check("err", 256'(err), 256'(exp_err));
`endif
    if (exp_vld) begin
      if (exp_q.size() == 0) begin
        check("so_queue_empty", 256'(exp_q.size()), 256'(1));
      end else begin
        e = exp_q.pop_front();
        check("so", 256'(so), 256'(e));
      end
    end else begin
      check("so_idle_zero", 256'(so), 256'(0));
    end
    if (so_vld && got_idx < DW) begin
      got_word[got_idx] = so;
      got_idx++;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    exp_start = 1'b0;
  endtask

  task automatic idle(input int n);
    cs_n = 1'b1;
    repeat (n) step();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cs_n = 1'b1;
    core_done = 1'b0;
    exp_busy = 1'b0;
    exp_vld = 1'b0;
    exp_start = 1'b0;
    exp_err = 1'b0;
    exp_data = '0;
    exp_key = '0;
    exp_q.delete();
    #1;
    check("async_rst_busy", 256'(busy), 256'(0));
    check("async_rst_so_vld", 256'(so_vld), 256'(0));
    check("async_rst_data", 256'(core_data), 256'(0));
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send_bits(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input int abort_at, input int spur_at, input int rst_at);
    for (int i = 0; i < DW + KW; i++) begin
      if (i == rst_at) begin
        apply_reset();
        return;
      end
      if (i == abort_at) begin
        cs_n = 1'b1;
        step();
        exp_busy = 1'b0;
        exp_err = 1'b1;
        return;
      end
      cs_n = 1'b0;
      si = (i < DW) ? d[i] : k[i - DW];
      core_done = (i == spur_at);
      step();
      core_done = 1'b0;
      if (i < DW) exp_data[i] = si;
      else exp_key[i - DW] = si;
      exp_busy = 1'b1;
      if (i == 0) exp_err = 1'b0;
      if (i == spur_at) exp_err = 1'b1;
      if (i == DW + KW - 1) exp_start = 1'b1;
    end
  endtask

  task automatic do_tx(input logic [DW-1:0] res, input int lat, input logic csn_wait,
                       input int abort_at, input int rst_at);
    for (int c = 0; c < lat; c++) begin
      cs_n = csn_wait;
      si = 1'($urandom_range(0, 1));
      step();
    end
    cs_n = 1'b0;
    core_done = 1'b1;
    core_result = res;
    got_idx = 0;
    step();
    core_done = 1'b0;
    exp_q.delete();
    for (int b = 0; b < DW; b++) exp_q.push_back(res[b]);
    exp_vld = 1'b1;
    for (int b = 1; b < DW; b++) begin
      if (b == rst_at) begin
        apply_reset();
        return;
      end
      if (b == abort_at) begin
        cs_n = 1'b1;
        step();
        exp_vld = 1'b0;
        exp_busy = 1'b0;
        exp_err = 1'b1;
        exp_q.delete();
        return;
      end
      step();
    end
    step();
    exp_vld = 1'b0;
    exp_busy = 1'b0;
    check("so_vld_cycles", 256'(got_idx), 256'(DW));
    check("tx_reassembled", 256'(got_word), 256'(res));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic full_frame(input int lat);
    logic [DW-1:0] d, r;
    logic [KW-1:0] k;
    d = rnd128();
    k = rnd128();
    r = rnd128();
    send_bits(d, k, -1, -1, -1);
    do_tx(r, lat, 1'b0, -1, -1);
  endtask

  // stimulus and final report
  initial begin
    n_vec = 0;
    n_err = 0;
    got_idx = 0;
    got_word = '0;
    rst = 1'b1;
    cs_n = 1'b1;
    si = 1'b0;
    core_done = 1'b0;
    core_result = '0;
    exp_busy = 1'b0;
    exp_vld = 1'b0;
    exp_start = 1'b0;
    exp_err = 1'b0;
    exp_data = '0;
    exp_key = '0;
    repeat (2) step();
    rst = 1'b0;
    idle(2);

    // 1: FIPS-197 nominal frame
    send_bits(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, -1, -1, -1);
    check("t1_core_data", 256'(core_data), 256'(128'h00112233445566778899aabbccddeeff));
    check("t1_core_key", 256'(core_key), 256'(128'h000102030405060708090a0b0c0d0e0f));
    check("t1_start_pulse", 256'(core_start), 256'(1));
    do_tx(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, 1'b0, -1, -1);
    check("t1_result", 256'(got_word), 256'(128'h69c4e0d86a7b0430d8cdb78070b4c55a));
    check("t1_idle_busy", 256'(busy), 256'(0));
    idle(1);

    // 2: abort at bit 77, then a full frame
    send_bits(rnd128(), rnd128(), 77, -1, -1);
    check("t2_busy_after_abort", 256'(busy), 256'(0));
    idle(2);
    full_frame(4);
    idle(1);

    // 3: cs_n high through WAIT, result still returned
    send_bits(rnd128(), rnd128(), -1, -1, -1);
    do_tx(rnd128(), 5, 1'b1, -1, -1);
    idle(1);

    // 4: abort at TX bit 40, then a full frame
    send_bits(rnd128(), rnd128(), -1, -1, -1);
    do_tx(rnd128(), 3, 1'b0, 40, -1);
    check("t4_so_vld_after_abort", 256'(so_vld), 256'(0));
    idle(1);
    full_frame(7);
    idle(1);

    // 5: reset at bit 200 and during TX, then a clean frame
    send_bits(rnd128(), rnd128(), -1, -1, 200);
    idle(1);
    send_bits(rnd128(), rnd128(), -1, -1, -1);
    do_tx(rnd128(), 2, 1'b0, -1, 60);
    idle(1);
    full_frame(6);

    // a frame needs a cs_n rising edge first: holding cs_n low must not restart
    cs_n = 1'b0;
    repeat (3) step();
    check("t5_no_restart", 256'(busy), 256'(0));

    // 6: spurious core_done in IDLE and RX, then back-to-back frames
    cs_n = 1'b1;
    core_done = 1'b1;
    core_result = rnd128();
    step();
    core_done = 1'b0;
    exp_err = 1'b1;
    step();
    send_bits(rnd128(), rnd128(), -1, 30, -1);
    do_tx(rnd128(), 1, 1'b0, -1, -1);
    idle(1);
    full_frame(2);
    idle(1);
    full_frame(3);
    idle(1);

    // randomized frames mixing aborts and WAIT-phase cs_n
    for (int n = 0; n < 10; n++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      case (mode)
        1: send_bits(rnd128(), rnd128(), int'($urandom_range(1, 255)), -1, -1);
        2: begin
          send_bits(rnd128(), rnd128(), -1, -1, -1);
          do_tx(rnd128(), int'($urandom_range(1, 12)), 1'b0, int'($urandom_range(1, 127)), -1);
        end
        3: begin
          send_bits(rnd128(), rnd128(), -1, int'($urandom_range(1, 255)), -1);
          do_tx(rnd128(), int'($urandom_range(1, 12)), 1'b1, -1, -1);
        end
        default: full_frame(int'($urandom_range(1, 12)));
      endcase
      idle(int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
